load_store_unit: RTL and testbench

Parametrised data-memory access unit for the multi-cycle RISC-V core. It takes one load/store request at a time from the execute stage and drives the picorv32-style memory bus. It performs byte-lane steering, sign/zero extension and, optionally, splits misaligned accesses into two word transactions instead of trapping. A bus watchdog converts a stalled memory into a fault response.

---
 rtl/load_store_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access unit with byte-lane steering,
// sign/zero extension, optional misaligned split and bus watchdog.
module load_store_unit #(
  parameter int unsigned MISALIGN_SPLIT = 1,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_t;

  state_t        state;
  logic          write_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata0;
  logic [CW-1:0] cnt;

  logic          mis_in;
  logic          bad_in;
  logic [7:0]    mk_in;
  logic [63:0]   wd_in;
  logic [7:0]    mk_q;
  logic [63:0]   wd_q;
  logic [2:0]    end_q;
  logic          cross_q;
  logic          tmo;

  function automatic logic [2:0] nbytes(
    input logic [1:0] sz
  );
    unique case (sz)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [7:0] base;
    unique case (sz)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    lane_mask = base << off;
  endfunction

  function automatic logic [63:0] lane_data(
    input logic [31:0] w,
    input logic [1:0]  off
  );
    lane_data = {32'b0, w} << {off, 3'b000};
  endfunction

  function automatic logic [31:0] ext(
    input logic [63:0] d,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic        sgn
  );
    logic [31:0] s;
    s = 32'(d >> {off, 3'b000});
    unique case (sz)
      2'd0:    ext = {{24{sgn & s[7]}}, s[7:0]};
      2'd1:    ext = {{16{sgn & s[15]}}, s[15:0]};
      default: ext = s;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign mem_instr = 1'b0;

  assign mis_in =
    (req_size == 2'd1 && req_addr[0]) ||
    (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign bad_in = (req_size == 2'd3) ||
    (mis_in && MISALIGN_SPLIT == 0);
  assign mk_in = lane_mask(req_size, req_addr[1:0]);
  assign wd_in = lane_data(req_wdata, req_addr[1:0]);

  assign mk_q    = lane_mask(size_q, off_q);
  assign wd_q    = lane_data(wdata_q, off_q);
  assign end_q   = {1'b0, off_q} + nbytes(size_q);
  assign cross_q = end_q > 3'd4;

  assign tmo = (TIMEOUT > 0) && !mem_ready &&
    (cnt == TMO_LAST);

  // request sequencing, bus driving and response generation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      sgn_q     <= 1'b0;
      off_q     <= 2'd0;
      wdata_q   <= 32'd0;
      rdata0    <= 32'd0;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            cnt     <= '0;
            if (bad_in) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              state     <= ACC0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_write ? mk_in[3:0] : 4'd0;
              mem_wdata <= wd_in[31:0];
            end
          end
        end
        ACC0: begin
          if (mem_ready) begin
            cnt    <= '0;
            rdata0 <= mem_rdata;
            if (cross_q) begin
              state     <= ACC1;
              mem_addr  <= mem_addr + 32'd4;
              mem_wstrb <= write_q ? mk_q[7:4] : 4'd0;
              mem_wdata <= wd_q[63:32];
            end else begin
              state     <= RESP;
              mem_valid <= 1'b0;
              mem_wstrb <= 4'd0;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b0;
              rsp_rdata <= write_q ? 32'd0 :
                ext({32'd0, mem_rdata}, off_q,
                    size_q, sgn_q);
            end
          end else if (tmo) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            mem_wstrb <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACC1: begin
          if (mem_ready) begin
            cnt       <= '0;
            state     <= RESP;
            mem_valid <= 1'b0;
            mem_wstrb <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= write_q ? 32'd0 :
              ext({mem_rdata, rdata0}, off_q,
                  size_q, sgn_q);
          end else if (tmo) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            mem_wstrb <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit,
// split/watchdog instance plus a fault-on-misalign instance.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] rd_lo, rd_hi, hi_addr;

  logic        a_rdy, a_rv, a_rf, a_mv, a_mi;
  logic [31:0] a_rd, a_ma, a_mw;
  logic [3:0]  a_ms;
  logic        b_rdy, b_rv, b_rf, b_mv, b_mi;
  logic [31:0] b_rd, b_ma, b_mw;
  logic [3:0]  b_ms;

  logic        m_ready, m_rv, m_rf, m_mv;
  logic [31:0] m_rd, m_ma, m_mw;
  logic [3:0]  m_ms;

  assign m_ready = sel ? a_rdy : b_rdy;
  assign m_rv    = sel ? a_rv  : b_rv;
  assign m_rf    = sel ? a_rf  : b_rf;
  assign m_rd    = sel ? a_rd  : b_rd;
  assign m_mv    = sel ? a_mv  : b_mv;
  assign m_ma    = sel ? a_ma  : b_ma;
  assign m_mw    = sel ? a_mw  : b_mw;
  assign m_ms    = sel ? a_ms  : b_ms;
  assign mem_rdata = (m_ma == hi_addr) ? rd_hi : rd_lo;

  load_store_unit #(
    .MISALIGN_SPLIT(1),
    .TIMEOUT(8)
  ) u_dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid & sel), .req_ready(a_rdy),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rd),
    .rsp_fault(a_rf),
    .mem_valid(a_mv), .mem_instr(a_mi),
    .mem_ready(mem_ready & sel), .mem_addr(a_ma),
    .mem_wdata(a_mw), .mem_wstrb(a_ms),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(
    .MISALIGN_SPLIT(0),
    .TIMEOUT(0)
  ) u_dut0 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid & ~sel), .req_ready(b_rdy),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rd),
    .rsp_fault(b_rf),
    .mem_valid(b_mv), .mem_instr(b_mi),
    .mem_ready(mem_ready & ~sel), .mem_addr(b_ma),
    .mem_wdata(b_mw), .mem_wstrb(b_ms),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    int          lat;
  } rsp_t;

  bus_t bq[$];
  rsp_t rq[$];
  rsp_t er;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   wait_cnt = 0;
  int   acc_at = 0;
  int   a1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic exp_bus(
    input logic [31:0] a,
    input logic [3:0]  s,
    input logic [31:0] d
  );
    bq.push_back(bus_t'{a, s, d});
  endtask

  // bus and response monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      if (m_mv) begin
        if (!mem_ready) wait_cnt++;
        chk("bus_expected", bq.size() != 0, 1);
        if (bq.size() != 0) begin
          chk("mem_addr", m_ma, bq[0].addr);
          chk("mem_wstrb", {28'd0, m_ms},
              {28'd0, bq[0].strb});
          if (bq[0].strb != 4'd0)
            chk("mem_wdata", m_mw, bq[0].data);
          if (mem_ready) void'(bq.pop_front());
        end
      end
      if (m_rv) begin
        chk("rsp_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          er = rq.pop_front();
          chk("rsp_rdata", m_rd, er.rdata);
          chk("rsp_fault", m_rf, er.fault);
          chk("rsp_latency", cyc - er.acc, er.lat);
        end
      end
    end
  end

  task automatic issue(
    input logic        w,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] xr,
    input logic        xf,
    input int          lat,
    input bit          want
  );
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", m_ready, 1);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    acc_at = cyc;
    #1 req_valid = 1'b0;
    if (want) rq.push_back(rsp_t'{xr, xf, acc_at, lat});
  endtask

  task automatic drain(input bit rsp_only);
    int n = 0;
    while ((rq.size() != 0 ||
            (!rsp_only && bq.size() != 0) ||
            !m_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", n < 50, 1);
  endtask

  initial begin
    sel = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'd0;
    req_signed = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    mem_ready = 1'b1;
    rd_lo = 32'd0;
    rd_hi = 32'd0;
    hi_addr = 32'h104;
    #1 resetn = 1'b0;
    #11;
    chk("rst_req_ready", a_rdy, 1);
    chk("rst_mem_valid", a_mv, 0);
    chk("rst_rsp_valid", a_rv, 0);
    chk("rst_mem_addr", a_ma, 0);
    chk("rst_mem_wstrb", {28'd0, a_ms}, 0);
    chk("rst_rsp_rdata", a_rd, 0);
    @(negedge clk);
    resetn = 1'b1;

    rd_lo = 32'hDEADBEEF;
    exp_bus(32'h100, 4'b0000, 32'h0);
    issue(0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 2, 1);
    a1 = acc_at;
    exp_bus(32'h100, 4'b0000, 32'h0);
    issue(0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 2, 1);
    chk("throughput", acc_at - a1, 3);
    drain(0);

    rd_lo = 32'h80123456;
    exp_bus(32'h100, 4'b0000, 32'h0);
    issue(0, 0, 1, 32'h103, 0, 32'hFFFFFF80, 0, 2, 1);
    exp_bus(32'h100, 4'b0000, 32'h0);
    issue(0, 0, 0, 32'h103, 0, 32'h00000080, 0, 2, 1);
    drain(0);

    exp_bus(32'h100, 4'b1100, 32'h33440000);
    exp_bus(32'h104, 4'b0011, 32'h00001122);
    issue(1, 2, 0, 32'h102, 32'h11223344, 0, 0, 3, 1);
    drain(0);

    rd_lo = 32'hAB000000;
    rd_hi = 32'h000000CD;
    hi_addr = 32'h0;
    exp_bus(32'hFFFFFFFC, 4'b0000, 32'h0);
    exp_bus(32'h00000000, 4'b0000, 32'h0);
    issue(0, 1, 1, 32'hFFFFFFFF, 0,
          32'hFFFFCDAB, 0, 3, 1);
    drain(0);

    hi_addr = 32'h104;
    rd_lo = 32'h12345678;
    exp_bus(32'h100, 4'b0110, 32'h00BEEF00);
    issue(1, 1, 0, 32'h101, 32'h0000BEEF, 0, 0, 2, 1);
    exp_bus(32'h100, 4'b0000, 32'h0);
    issue(0, 1, 0, 32'h101, 0, 32'h00003456, 0, 2, 1);
    issue(0, 3, 0, 32'h100, 0, 32'h0, 1, 1, 1);
    exp_bus(32'h4, 4'b1000, 32'hAA000000);
    issue(1, 0, 0, 32'h7, 32'h000000AA, 0, 0, 2, 1);
    drain(0);

    rd_lo = 32'h80010000;
    exp_bus(32'h0, 4'b0000, 32'h0);
    issue(0, 1, 1, 32'h2, 0, 32'hFFFF8001, 0, 2, 1);
    exp_bus(32'h200, 4'b1111, 32'hCAFEF00D);
    issue(1, 2, 0, 32'h200, 32'hCAFEF00D, 0, 0, 2, 1);
    drain(0);

    rd_lo = 32'h11223344;
    rd_hi = 32'h55667788;
    exp_bus(32'h100, 4'b0000, 32'h0);
    exp_bus(32'h104, 4'b0000, 32'h0);
    issue(0, 2, 0, 32'h103, 0, 32'h66778811, 0, 3, 1);
    drain(0);

    sel = 1'b0;
    rd_lo = 32'h13572468;
    issue(0, 2, 0, 32'h102, 0, 32'h0, 1, 1, 1);
    issue(0, 3, 1, 32'h100, 0, 32'h0, 1, 1, 1);
    exp_bus(32'h100, 4'b0000, 32'h0);
    issue(0, 2, 0, 32'h100, 0, 32'h13572468, 0, 2, 1);
    drain(0);

    sel = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    wait_cnt = 0;
    exp_bus(32'h200, 4'b0000, 32'h0);
    issue(0, 2, 0, 32'h200, 0, 32'h0, 1, 9, 1);
    drain(1);
    chk("wd_wait_cycles", wait_cnt, 8);
    chk("wd_mem_valid", a_mv, 0);
    bq.delete();
    mem_ready = 1'b1;

    @(negedge clk);
    mem_ready = 1'b0;
    exp_bus(32'h300, 4'b0000, 32'h0);
    issue(0, 2, 0, 32'h300, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_mem_valid", a_mv, 0);
    chk("rst_mid_req_ready", a_rdy, 1);
    chk("rst_mid_rsp_valid", a_rv, 0);
    bq.delete();
    @(negedge clk);
    resetn = 1'b1;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);

    rd_lo = 32'h0BADF00D;
    exp_bus(32'h100, 4'b0000, 32'h0);
    issue(0, 2, 0, 32'h100, 0, 32'h0BADF00D, 0, 2, 1);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
